// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC (-> MEM), owns the PC.
// Optional debug single-step (HOLD state and `step` port) is enabled by defining CTRL_STEP_EN.
module cpu_ctrl_fsm #(
    parameter int            PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      instr_type,
    input  logic            wb,
    input  logic [7:0]      opcode,
    input  logic [PC_W-1:0] rtarget,
    input  logic            mem_ack,
`ifdef CTRL_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] pc,
    output logic            mem_req,
    output logic            mem_we,
    output logic            addr_sel,
    output logic            ir_en,
    output logic            reg_we,
    output logic [1:0]      wb_sel,
    output logic            flags_en,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [1:0] T_RTYPE = 2'b00;
    localparam logic [1:0] T_ITYPE = 2'b01;
    localparam logic [1:0] T_PTYPE = 2'b10;
    localparam logic [1:0] T_JTYPE = 2'b11;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_JALR = 8'h48;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

`ifdef CTRL_STEP_EN
    localparam state_t DONE_STATE  = HOLD;
    localparam state_t RESET_STATE = HOLD;
`else
    localparam state_t DONE_STATE  = FETCH;
    localparam state_t RESET_STATE = FETCH;
`endif

    state_t          state_q;
    state_t          state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_en    = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        flags_en = 1'b0;

        // Reset silences every strobe so an abandoned instruction writes nothing.
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_en   = mem_ack;
                    if (mem_ack) state_d = DECODE;
                end
                DECODE: begin
                    state_d = EXEC;
                end
                EXEC: begin
                    case (instr_type)
                        T_RTYPE, T_ITYPE: begin
                            reg_we   = wb;
                            // NOP and an untaken Jcond leave the flags alone.
                            flags_en = !((opcode == OP_NOP) || (opcode[7:4] == 4'h4));
                            pc_d     = pc_inc;
                            state_d  = DONE_STATE;
                        end
                        T_PTYPE: begin
                            state_d = MEM;
                        end
                        T_JTYPE: begin
                            if (opcode == OP_JALR) begin
                                reg_we = 1'b1;
                                wb_sel = WB_LINK;
                            end
                            pc_d    = rtarget;
                            state_d = DONE_STATE;
                        end
                        default: begin
                            pc_d    = pc_inc;
                            state_d = DONE_STATE;
                        end
                    endcase
                end
                MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = opcode[2];
                    if (mem_ack) begin
                        if (!opcode[2]) begin
                            reg_we = 1'b1;
                            wb_sel = WB_MEM;
                        end
                        pc_d    = pc_inc;
                        state_d = DONE_STATE;
                    end
                end
`ifdef CTRL_STEP_EN
                HOLD: begin
                    if (step) state_d = FETCH;
                end
`endif
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign pc    = pc_q;
    assign state = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: a per-instruction trace model feeds an expected queue
// that a single compare process checks every cycle; a few literal PC checks pin the model.
module tb_cpu_ctrl_fsm;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic        clk;
    logic        reset;
    logic [1:0]  instr_type;
    logic        wb;
    logic [7:0]  opcode;
    logic [15:0] rtarget;
    logic        mem_ack;
    logic        step;
    logic [15:0] pc;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_en;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        flags_en;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    // {full_check, state[2:0], pc[15:0], req, we, asel, ir, rwe, wb_sel[1:0], flags}
    logic [27:0] exp_q[$];
    logic [15:0] mpc;

    cpu_ctrl_fsm #(.PC_W(16), .RESET_PC(RST_PC)) dut (
        .clk(clk),
        .reset(reset),
        .instr_type(instr_type),
        .wb(wb),
        .opcode(opcode),
        .rtarget(rtarget),
        .mem_ack(mem_ack),
`ifdef CTRL_STEP_EN
        .step(step),
`endif
        .pc(pc),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .addr_sel(addr_sel),
        .ir_en(ir_en),
        .reg_we(reg_we),
        .wb_sel(wb_sel),
        .flags_en(flags_en),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [27:0] mk(input logic full, input logic [2:0] st,
                                       input logic [15:0] p, input logic req, input logic we,
                                       input logic asel, input logic ir, input logic rwe,
                                       input logic [1:0] wsel, input logic fen);
        return {full, st, p, req, we, asel, ir, rwe, wsel, fen};
    endfunction

    // Compare process: one expected record per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [27:0] e;
            e = exp_q.pop_front();
            check("strobes", {8'h00, mem_req, mem_we, addr_sel, ir_en, reg_we, wb_sel, flags_en},
                  {8'h00, e[7:0]});
            if (e[27]) begin
                check("state", {13'h0, state}, {13'h0, e[26:24]});
                check("pc", pc, e[23:8]);
            end
        end
    end

    task automatic cyc(input logic ack, input logic rst, input logic [27:0] e);
        mem_ack = ack;
        reset   = rst;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_expect(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, mk(1'b1, 3'd4, mpc, 0, 0, 0, 0, 0, 2'b00, 0));
    endtask

    task automatic leading_hold();
`ifdef CTRL_STEP_EN
        step = 1'b1;
        cyc(1'b0, 1'b0, mk(1'b1, 3'd4, mpc, 0, 0, 0, 0, 0, 2'b00, 0));
`endif
    endtask

    task automatic fetch_decode(input int nf);
        leading_hold();
        for (int i = 0; i < nf; i++) cyc(1'b0, 1'b0, mk(1'b1, 3'd0, mpc, 1, 0, 0, 0, 0, 2'b00, 0));
        cyc(1'b1, 1'b0, mk(1'b1, 3'd0, mpc, 1, 0, 0, 1, 0, 2'b00, 0));
        cyc(1'b0, 1'b0, mk(1'b1, 3'd1, mpc, 0, 0, 0, 0, 0, 2'b00, 0));
    endtask

    // Whole instruction from the instruction-level rules: builds the expected trace as it drives.
    task automatic run_instr(input logic [1:0] t, input logic w, input logic [7:0] op,
                             input logic [15:0] rt, input int nf, input int nm);
        logic fen;
        logic jalr;
        logic load;
        instr_type = t;
        wb         = w;
        opcode     = op;
        rtarget    = rt;
        fetch_decode(nf);
        case (t)
            2'b00, 2'b01: begin
                fen = !(op == 8'h00 || op[7:4] == 4'h4);
                cyc(1'b0, 1'b0, mk(1'b1, 3'd2, mpc, 0, 0, 0, 0, w, 2'b00, fen));
                mpc = mpc + 16'd1;
            end
            2'b10: begin
                load = !op[2];
                cyc(1'b0, 1'b0, mk(1'b1, 3'd2, mpc, 0, 0, 0, 0, 0, 2'b00, 0));
                for (int i = 0; i < nm; i++)
                    cyc(1'b0, 1'b0, mk(1'b1, 3'd3, mpc, 1, op[2], 1, 0, 0, 2'b00, 0));
                cyc(1'b1, 1'b0, mk(1'b1, 3'd3, mpc, 1, op[2], 1, 0, load,
                                   load ? 2'b01 : 2'b00, 0));
                mpc = mpc + 16'd1;
            end
            default: begin
                jalr = (op == 8'h48);
                cyc(1'b0, 1'b0, mk(1'b1, 3'd2, mpc, 0, 0, 0, 0, jalr, jalr ? 2'b10 : 2'b00, 0));
                mpc = rt;
            end
        endcase
    endtask

    initial begin
        reset      = 1'b1;
        instr_type = 2'b00;
        wb         = 1'b0;
        opcode     = 8'h00;
        rtarget    = 16'h0000;
        mem_ack    = 1'b1;
        step       = 1'b1;
        @(posedge clk);
        #1;

        // Reset held two cycles with mem_ack high: strobes must stay silent.
        cyc(1'b1, 1'b1, mk(1'b0, 3'd0, 16'h0, 0, 0, 0, 0, 0, 2'b00, 0));
        cyc(1'b1, 1'b1, mk(1'b0, 3'd0, 16'h0, 0, 0, 0, 0, 0, 2'b00, 0));
        mpc = RST_PC;

`ifdef CTRL_STEP_EN
        step = 1'b0;
        idle_expect(3);
`endif

        run_instr(2'b00, 1'b1, 8'h05, 16'h0, 0, 0);       // ADD
        check("pc_after_add", pc, 16'h0011);
        check("model_after_add", mpc, pc);
`ifdef CTRL_STEP_EN
        step = 1'b0;
        idle_expect(2);
`endif
        run_instr(2'b00, 1'b0, 8'h0B, 16'h0, 1, 0);       // CMP, one fetch wait
        run_instr(2'b10, 1'b1, 8'h40, 16'h0, 0, 2);       // LOAD, two MEM waits
        run_instr(2'b10, 1'b1, 8'h44, 16'h0, 2, 1);       // STOR
        check("pc_after_mem", pc, 16'h0014);
        run_instr(2'b11, 1'b0, 8'h4C, 16'h0020, 0, 0);    // taken Jcond
        check("pc_after_jcond", pc, 16'h0020);
        run_instr(2'b11, 1'b1, 8'h48, 16'h0100, 0, 0);    // JALR
        check("pc_after_jalr", pc, 16'h0100);
        run_instr(2'b00, 1'b0, 8'h4C, 16'h0300, 0, 0);    // untaken Jcond
        run_instr(2'b01, 1'b0, 8'h00, 16'h0, 0, 0);       // NOP
        check("pc_after_nop", pc, 16'h0102);
        run_instr(2'b01, 1'b1, 8'h12, 16'h0, 1, 0);       // iType ALU op
        run_instr(2'b11, 1'b0, 8'h4C, 16'hFFFF, 0, 0);
        run_instr(2'b00, 1'b1, 8'h05, 16'h0, 0, 0);       // ADD at FFFF wraps
        check("pc_wrap", pc, 16'h0000);

        // STOR interrupted by reset while waiting in MEM.
        instr_type = 2'b10;
        wb         = 1'b0;
        opcode     = 8'h44;
        fetch_decode(0);
        cyc(1'b0, 1'b0, mk(1'b1, 3'd2, mpc, 0, 0, 0, 0, 0, 2'b00, 0));
        cyc(1'b0, 1'b0, mk(1'b1, 3'd3, mpc, 1, 1, 1, 0, 0, 2'b00, 0));
        cyc(1'b0, 1'b1, mk(1'b1, 3'd3, mpc, 0, 0, 0, 0, 0, 2'b00, 0));
        mpc = RST_PC;
        check("pc_after_mid_reset", pc, RST_PC);
        run_instr(2'b00, 1'b1, 8'h05, 16'h0, 0, 0);
        check("pc_after_restart", pc, 16'h0011);

        mem_ack = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control sequencer for the 16-bit CPU. It owns the program counter and steps each instruction through fetch, decode, execute and memory access. It drives the instruction-register, regfile, flags and memory strobes from the instruction decoder's `type`, `wb` and `opcode` outputs. It sits between the shared instruction/data memory port, the decoder and the regfile/ALU datapath.

## Interface
- `PC_W`, 16, width of program counter and memory address.
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `type`  in  2  decoder instruction type: 00 rType, 01 iType, 10 pType, 11 jType.
- `wb`  in  1  decoder writeback request.
- `opcode`  in  8  decoder concatenated opcode, {instr[15:12], instr[7:4]}.
- `rtarget`  in  PC_W  register value selected by mux B, used as the jump target.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `pc`  out  PC_W  current program counter (registered).
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  memory write strobe; valid only while `mem_req` is high.
- `addr_sel`  out  1  memory address select: 0 = `pc`, 1 = register (mux A).
- `ir_en`  out  1  load instruction register from memory read data.
- `reg_we`  out  1  regfile write enable for `en_reg`.
- `wb_sel`  out  2  regfile write source: 00 ALU, 01 memory data, 10 `pc`+1.
- `flags_en`  out  1  capture ALU flags.
- `state`  out  3  current state, for debug: FETCH=0, DECODE=1, EXEC=2, MEM=3, HOLD=4.

## Operation
- **Output timing:** strobes are combinational from `state` and inputs. `pc` and `state` are registered.
- **Reset:** while `reset` is high, all strobes are 0 and `wb_sel`=00. On the next edge, `pc`=RESET_PC and `state`=FETCH (HOLD when `CTRL_STEP_EN` is defined).
- **Reset mid-instruction:** reset during any state abandons the instruction. There is no partial regfile, flags or memory write.
- **FETCH:** `mem_req`=1, `addr_sel`=0, `mem_we`=0.
  - `ir_en` equals `mem_ack`.
  - On `mem_ack`, go to DECODE; otherwise stay.
- **DECODE:** single cycle, no strobes, lets the decoder settle. Go to EXEC.
- **EXEC**, rType or iType:
  - `reg_we`=`wb`, `wb_sel`=00.
  - `flags_en`=1 unless `opcode`==8'h00 (NOP) or `opcode[7:4]`==4'h4 (an untaken Jcond reported as rType).
  - `pc`<=`pc`+1, go to FETCH.
- **EXEC**, pType: no strobes, go to MEM.
- **EXEC**, jType:
  - `pc`<=`rtarget`.
  - If `opcode`==8'h48 (JALR): `reg_we`=1, `wb_sel`=10, so the link value is `pc`+1 computed from the pre-update `pc`.
  - Taken Jcond (8'h4C): no register write.
  - Go to FETCH.
- **MEM:** `mem_req`=1, `addr_sel`=1.
  - `mem_we`=`opcode[2]` (STOR 8'h44 writes, LOAD 8'h40 reads). The `wb` input is ignored for pType.
  - On `mem_ack`: for LOAD, `reg_we`=1 and `wb_sel`=01. Then `pc`<=`pc`+1 and go to FETCH.
  - Without `mem_ack`, stay with all outputs stable.
- **Arithmetic:** PC increments are modulo 2^PC_W; 16'hFFFF+1 wraps to 0.
- **Unrecognised inputs:** any `type` value not covered above (including X) in EXEC is treated as NOP: no strobes, `pc`+1.

## Timing
- `mem_ack` may be asserted in the first cycle of a request (zero wait), or held low for any number of cycles.
- ALU/NOP/jump instruction: 3 cycles with zero-wait memory (FETCH, DECODE, EXEC); plus N FETCH wait cycles.
- LOAD/STOR: 4 cycles with zero-wait memory, plus fetch waits and MEM waits.
- `ir_en` and `reg_we` are single-cycle pulses, coincident with the completing edge.
- `pc` changes only on the EXEC edge (non-pType) or on the MEM edge that sees `mem_ack`.

## Configuration
- `CTRL_STEP_EN` defined:
  - Adds port `step  in  1`, a debug single-step request.
  - On completion, EXEC and MEM go to HOLD instead of FETCH.
  - HOLD asserts no strobes and goes to FETCH on a cycle with `step`=1.
  - If `step` is held high, execution proceeds one instruction per HOLD visit (one extra cycle each).
- `CTRL_STEP_EN` undefined:
  - No `step` port and HOLD is unreachable.
  - Completion goes straight to FETCH.

## Test plan
- **Reset:** hold `reset` 2 cycles with RESET_PC=16'h0010 -> all strobes 0 during reset; next cycle `state`=0, `pc`=16'h0010, `mem_req`=1, `addr_sel`=0.
- **ADD, zero wait:** `mem_ack`=1, `type`=00, `wb`=1, `opcode`=8'h05 -> `ir_en` at cycle 1, `reg_we`=1 and `flags_en`=1 at cycle 3, `pc` 0010->0011; CMP (8'h0B, `wb`=0) gives `flags_en`=1, `reg_we`=0.
- **LOAD with waits:** `opcode`=8'h40, `type`=10, `mem_ack` low 2 cycles in MEM -> `mem_req`=1 with `addr_sel`=1 and `mem_we`=0 for 3 cycles, then `reg_we`=1 with `wb_sel`=01 on the ack cycle, `pc`+1; STOR (8'h44) gives `mem_we`=1 and `reg_we`=0.
- **JALR:** at `pc`=16'h0020, `opcode`=8'h48, `type`=11, `rtarget`=16'h0100 -> `reg_we`=1, `wb_sel`=10, next `pc`=16'h0100.
- **Jcond:** taken (`type`=11, 8'h4C) -> `pc`=`rtarget`, no `reg_we`. Untaken (`type`=00, 8'h4C) -> `pc`+1, `flags_en`=0, `reg_we`=0.
- **Boundaries:**
  - `pc`=16'hFFFF running an ADD -> `pc`=0.
  - `reset` asserted in MEM during a STOR with `mem_ack`=0 -> `mem_we`=0 in that cycle, `pc` = RESET_PC.
  - With `CTRL_STEP_EN` defined: `state` stays 4 until `step` pulses, then exactly one instruction executes.
